ram_port_arbiter: RTL

Arbitrates the single-port 512×32 RAM between two requesters: the CPU datapath memory path (MAR/MDR, driven by the control unit) and a DMA/debug loader port. It sits between those requesters and the RAM. Each cycle it grants at most one access, drives the RAM strobes, address and write data, and routes the one-cycle-late read data back to the owner. It also produces a stall for the control unit while the CPU is refused.

---
 rtl/ram_port_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter between the CPU memory path and a DMA/debug loader.
// Define RAM_ARB_STARVE_GUARD_EN to add the DMA starvation guard.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDma} owner_e;

  owner_e rd_owner_q, rd_owner_d;
  logic   lock_q, lock_d;
  logic   force_dma;

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  assign force_dma = (starve_q == StarveMax);

  always_comb begin
    starve_d = starve_q;
    if (!dma_req || dma_gnt) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_dma = 1'b0;
`endif

  // Reset gates the grants combinationally so nothing issues while reset is low.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (reset) begin
      if ((lock_q || force_dma) && dma_req) begin
        dma_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_read  = ~cpu_we;
      ram_write = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      ram_read  = ~dma_we;
      ram_write = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end
  end

  always_comb begin
    rd_owner_d = OwnNone;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = OwnCpu;
    end else if (dma_gnt && !dma_we) begin
      rd_owner_d = OwnDma;
    end
  end

  // Lock is taken on a locked DMA grant and dropped as soon as req or lock falls.
  assign lock_d = dma_req && dma_lock && (lock_q || dma_gnt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_q     <= 1'b0;
      rd_owner_q <= OwnNone;
    end else begin
      lock_q     <= lock_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // An in-flight read is discarded when reset is asserted on its data cycle.
  assign cpu_rvalid = reset && (rd_owner_q == OwnCpu);
  assign dma_rvalid = reset && (rd_owner_q == OwnDma);
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
  assign dma_rdata  = dma_rvalid ? ram_rdata : '0;
  assign cpu_stall  = reset && cpu_req && !cpu_gnt;

endmodule
